// File: rtl/fp_rr_arbiter.sv
// fp_rr_arbiter: fixed-priority queue arbiter with round-robin tie-break and a 2-cycle flush after each grant.
// Define FP_AGING_EN to add saturating per-queue age counters that lift starved queues above all non-aged ones.
module fp_rr_arbiter #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int PRIORITY_SIZE    = 4,
    parameter int AGE_SIZE         = 4,
    parameter int AGE_THRESHOLD    = 12
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [NUMBER_OF_QUEUES*PRIORITY_SIZE-1:0] priorities,
    input  logic [NUMBER_OF_QUEUES-1:0]               empty,
    input  logic                                      grant_ready,
    output logic                                      grant_valid,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]       grant_id,
    output logic [PRIORITY_SIZE-1:0]                  grant_priority
);
    localparam int N  = NUMBER_OF_QUEUES;
    localparam int P  = PRIORITY_SIZE;
    localparam int IW = $clog2(N);
`ifdef FP_AGING_EN
    localparam int KW = P + 2;
`else
    localparam int KW = P + 1;
`endif
    localparam logic [IW:0]   N_EXT   = (IW+1)'(N);
    localparam logic [IW-1:0] LAST_ID = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, GRANT, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [1:0]    flush_q, flush_d;
    logic [IW-1:0] rr_q, rr_d, id_q, id_d, win_id;
    logic [P-1:0]  gp_q, gp_d;
    logic [N-1:0]  req_q;
    logic [P-1:0]  prio_q [N];
    logic [KW-1:0] key [N];
    logic [KW-1:0] win_key;
    logic [IW:0]   idx;
    logic          hs;

    if (N < 2 || N > 64 || P < 1 || AGE_THRESHOLD < 1 || AGE_THRESHOLD >= (1 << AGE_SIZE)) begin : g_bad_cfg
        $error("fp_rr_arbiter: parameter out of range");
    end

    // Stage 1: registered request and priority snapshot.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            req_q[i]  <= reset ? 1'b0 : ~empty[i];
            prio_q[i] <= reset ? '0 : priorities[i*P +: P];
        end
    end

    assign hs = state_q == GRANT && grant_ready;

`ifdef FP_AGING_EN
    localparam logic [AGE_SIZE-1:0] AGE_TH = AGE_SIZE'(AGE_THRESHOLD);
    logic [AGE_SIZE-1:0] age_q [N];
    logic [AGE_SIZE-1:0] age_d [N];
    always_comb begin
        for (int i = 0; i < N; i++)
            age_d[i] = (empty[i] || (hs && id_q == IW'(i))) ? '0 : (&age_q[i] ? age_q[i] : age_q[i] + 1'b1);
    end
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++)
            age_q[i] <= reset ? '0 : age_d[i];
    end
    always_comb begin
        for (int i = 0; i < N; i++)
            key[i] = {req_q[i], age_q[i] >= AGE_TH, prio_q[i]};
    end
`else
    always_comb begin
        for (int i = 0; i < N; i++)
            key[i] = {req_q[i], prio_q[i]};
    end
`endif

    // Stage 2: cyclic scan from rr_q; strict compare keeps the first index among equal keys.
    always_comb begin
        win_id  = rr_q;
        win_key = key[rr_q];
        idx     = '0;
        for (int k = 1; k < N; k++) begin
            idx = {1'b0, rr_q} + (IW+1)'(k);
            idx = idx >= N_EXT ? idx - N_EXT : idx;
            if (key[idx[IW-1:0]] > win_key) begin
                win_id  = idx[IW-1:0];
                win_key = key[idx[IW-1:0]];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        rr_d    = rr_q;
        id_d    = id_q;
        gp_d    = gp_q;
        case (state_q)
            IDLE: if (|req_q) begin
                state_d = GRANT;
                id_d    = win_id;
                gp_d    = prio_q[win_id];
            end
            GRANT: if (hs) begin
                state_d = FLUSH;
                rr_d    = id_q == LAST_ID ? '0 : id_q + 1'b1;
            end
            // Two dead cycles let the consumer's pop reach empty and stage 1.
            FLUSH: begin
                flush_d = flush_q + 1'b1;
                if (flush_q == 2'd1) begin
                    state_d = IDLE;
                    flush_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            flush_q <= '0;
            rr_q    <= '0;
            id_q    <= '0;
            gp_q    <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            gp_q    <= gp_d;
        end
    end

    assign grant_valid    = state_q == GRANT;
    assign grant_id       = id_q;
    assign grant_priority = gp_q;
endmodule

// File: tb/tb_fp_rr_arbiter.sv
// tb_fp_rr_arbiter: directed scenarios plus randomized traffic checked against a cycle-level reference model.
module tb_fp_rr_arbiter;
`ifdef FP_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pri4 = '0;
    logic [3:0]  emp4 = '1;
    logic        rdy4 = 1'b0;
    logic        gv4, gva;
    logic [1:0]  gid4, gida;
    logic [3:0]  gpr4, gpra;
    logic [11:0] pri3 = '0;
    logic [2:0]  emp3 = '1;
    logic        rdy3 = 1'b0;
    logic        gv3;
    logic [1:0]  gid3;
    logic [3:0]  gpr3;
    int checks = 0, errors = 0, cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    fp_rr_arbiter #(.NUMBER_OF_QUEUES(4), .PRIORITY_SIZE(4), .AGE_SIZE(4), .AGE_THRESHOLD(15)) dut4 (
        .clock(clock), .reset(reset), .priorities(pri4), .empty(emp4), .grant_ready(rdy4),
        .grant_valid(gv4), .grant_id(gid4), .grant_priority(gpr4));
    fp_rr_arbiter #(.NUMBER_OF_QUEUES(4), .PRIORITY_SIZE(4), .AGE_SIZE(4), .AGE_THRESHOLD(4)) duta (
        .clock(clock), .reset(reset), .priorities(pri4), .empty(emp4), .grant_ready(rdy4),
        .grant_valid(gva), .grant_id(gida), .grant_priority(gpra));
    fp_rr_arbiter #(.NUMBER_OF_QUEUES(3), .PRIORITY_SIZE(4)) dut3 (
        .clock(clock), .reset(reset), .priorities(pri3), .empty(emp3), .grant_ready(rdy3),
        .grant_valid(gv3), .grant_id(gid3), .grant_priority(gpr3));

    // Reference model of dut4: grants are picked from the inputs seen one edge earlier.
    bit         m_valid, m_hs;
    logic [1:0] m_id, m_hid;
    logic [3:0] m_prio;
    int         m_rr, m_wait, m_best, m_win, m_j, m_key;
    int         m_age [4];
    int         p_prio [4];
    bit         p_req [4];
    always @(posedge clock) begin
        if (reset) begin
            m_valid = 0; m_id = 0; m_prio = 0; m_rr = 0; m_wait = 0;
            for (int i = 0; i < 4; i++) begin m_age[i] = 0; p_req[i] = 0; p_prio[i] = 0; end
        end else begin
            m_hs = m_valid && rdy4;
            m_hid = m_id;
            if (m_valid) begin
                if (rdy4) begin m_valid = 0; m_rr = (int'(m_id) + 1) % 4; m_wait = 2; end
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (p_req[0] || p_req[1] || p_req[2] || p_req[3]) begin
                m_best = -1; m_win = 0;
                for (int k = 0; k < 4; k++) begin
                    m_j = (m_rr + k) % 4;
                    m_key = (p_req[m_j] ? 32 : 0) + ((AGING && m_age[m_j] >= 15) ? 16 : 0) + p_prio[m_j];
                    if (m_key > m_best) begin m_best = m_key; m_win = m_j; end
                end
                m_valid = 1; m_id = 2'(m_win); m_prio = 4'(p_prio[m_win]);
            end
            for (int i = 0; i < 4; i++) begin
                m_age[i] = (!emp4[i] && !(m_hs && int'(m_hid) == i)) ? (m_age[i] < 15 ? m_age[i] + 1 : 15) : 0;
                p_req[i] = !emp4[i];
                p_prio[i] = int'(pri4[i*4 +: 4]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic do_reset;
        reset = 1'b1; tick(2); reset = 1'b0;
    endtask

    task automatic test_reset;
        pri4 = {4'd1, 4'd7, 4'd2, 4'd3}; emp4 = '0; rdy4 = 1'b0;
        reset = 1'b1; tick(3);
        checks++; if (gv4 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", gv4); end
        checks++; if (gid4 !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", gid4); end
        checks++; if (gpr4 !== 4'd0) begin errors++; $display("FAIL reset_prio got %0d want 0", gpr4); end
        reset = 1'b0; tick(1);
        checks++; if (gv4 !== 1'b0) begin errors++; $display("FAIL release_early got %b want 0", gv4); end
        tick(1);
        checks++;
        if (gv4 !== 1'b1 || gid4 !== 2'd2 || gpr4 !== 4'd7) begin
            errors++; $display("FAIL release_grant got v=%b id=%0d pr=%0d want v=1 id=2 pr=7", gv4, gid4, gpr4);
        end
    endtask

    task automatic test_reset_abort;
        reset = 1'b1; tick(1); reset = 1'b0;
        checks++; if (gv4 !== 1'b0) begin errors++; $display("FAIL abort_grant got %b want 0", gv4); end
        tick(1);
        checks++; if (gv4 !== 1'b0) begin errors++; $display("FAIL abort_early got %b want 0", gv4); end
        tick(1);
        checks++; if (gv4 !== 1'b1 || gid4 !== 2'd2) begin errors++; $display("FAIL abort_regrant got v=%b id=%0d want v=1 id=2", gv4, gid4); end
        pri4 = {4{4'd9}}; rdy4 = 1'b1; tick(1); rdy4 = 1'b0;
        checks++; if (gv4 !== 1'b0) begin errors++; $display("FAIL abort_hs got %b want 0", gv4); end
        reset = 1'b1; tick(1); reset = 1'b0; tick(1);
        checks++; if (gv4 !== 1'b0) begin errors++; $display("FAIL abort_flush got %b want 0", gv4); end
        tick(1);
        checks++; if (gv4 !== 1'b1 || gid4 !== 2'd0) begin errors++; $display("FAIL abort_rr got v=%b id=%0d want v=1 id=0", gv4, gid4); end
    endtask

    task automatic test_all_empty;
        emp4 = '1; pri4 = 16'($urandom); rdy4 = 1'b1; do_reset;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            checks++; if (gv4 !== 1'b0) begin errors++; $display("FAIL all_empty cycle %0d got %b want 0", i, gv4); end
        end
    endtask

    task automatic test_tie_rotate;
        int exp_id [4];
        int last, n;
        exp_id = '{0, 2, 0, 2};
        pri4 = {4'd3, 4'd9, 4'd5, 4'd9}; emp4 = '0; rdy4 = 1'b1; do_reset;
        last = 0;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (gv4 !== 1'b1 && n < 12) begin tick(1); n++; end
            checks++;
            if (gv4 !== 1'b1 || gid4 !== 2'(exp_id[g]) || gpr4 !== 4'd9) begin
                errors++; $display("FAIL tie_rotate #%0d got v=%b id=%0d pr=%0d want v=1 id=%0d pr=9", g, gv4, gid4, gpr4, exp_id[g]);
            end
            if (g > 0) begin
                checks++; if (cyc - last != 4) begin errors++; $display("FAIL tie_gap got %0d want 4", cyc - last); end
            end
            last = cyc;
            tick(1);
        end
    endtask

    task automatic test_latency_prio0;
        pri4 = {4'd15, 4'd15, 4'd0, 4'd15}; emp4 = '1; rdy4 = 1'b0; do_reset; tick(3);
        checks++; if (gv4 !== 1'b0) begin errors++; $display("FAIL latency_idle got %b want 0", gv4); end
        emp4 = 4'b1101; tick(1);
        checks++; if (gv4 !== 1'b0) begin errors++; $display("FAIL latency_early got %b want 0", gv4); end
        tick(1);
        checks++;
        if (gv4 !== 1'b1 || gid4 !== 2'd1 || gpr4 !== 4'd0) begin
            errors++; $display("FAIL latency_grant got v=%b id=%0d pr=%0d want v=1 id=1 pr=0", gv4, gid4, gpr4);
        end
    endtask

    task automatic test_hold_stable;
        int n;
        pri4 = {4'd1, 4'd2, 4'd12, 4'd3}; emp4 = '0; rdy4 = 1'b0; do_reset;
        n = 0;
        while (gv4 !== 1'b1 && n < 10) begin tick(1); n++; end
        checks++; if (gv4 !== 1'b1 || gid4 !== 2'd1 || gpr4 !== 4'd12) begin errors++; $display("FAIL hold_first got v=%b id=%0d pr=%0d want v=1 id=1 pr=12", gv4, gid4, gpr4); end
        for (int i = 0; i < 10; i++) begin
            pri4 = 16'($urandom); emp4 = 4'($urandom); tick(1);
            checks++;
            if (gv4 !== 1'b1 || gid4 !== 2'd1 || gpr4 !== 4'd12) begin
                errors++; $display("FAIL hold_stable cycle %0d got v=%b id=%0d pr=%0d want v=1 id=1 pr=12", i, gv4, gid4, gpr4);
            end
        end
        pri4 = {4'd1, 4'd2, 4'd12, 4'd3}; emp4 = 4'b1101; rdy4 = 1'b1; tick(1); rdy4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (gv4 !== 1'b0) begin errors++; $display("FAIL flush_gap cycle %0d got %b want 0", i, gv4); end
            tick(1);
        end
        checks++; if (gv4 !== 1'b1 || gid4 !== 2'd1) begin errors++; $display("FAIL post_flush got v=%b id=%0d want v=1 id=1", gv4, gid4); end
    endtask

    task automatic test_wrap_n3;
        int exp_id [5];
        int n;
        exp_id = '{0, 1, 2, 0, 1};
        pri3 = {3{4'd5}}; emp3 = '0; rdy3 = 1'b1; do_reset;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (gv3 !== 1'b1 && n < 12) begin tick(1); n++; end
            checks++;
            if (gv3 !== 1'b1 || gid3 !== 2'(exp_id[g]) || gpr3 !== 4'd5) begin
                errors++; $display("FAIL wrap_n3 #%0d got v=%b id=%0d pr=%0d want v=1 id=%0d pr=5", g, gv3, gid3, gpr3, exp_id[g]);
            end
            tick(1);
        end
        emp3 = '1; rdy3 = 1'b0;
    endtask

    task automatic test_aging;
        int first_q0, q0_cnt, grants, start;
        pri4 = {4'd0, 4'd0, 4'd15, 4'd1}; emp4 = 4'b1100; rdy4 = 1'b1; do_reset;
        first_q0 = -1; q0_cnt = 0; grants = 0; start = cyc;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (gva === 1'b1) begin
                grants++;
                if (gida === 2'd0) begin
                    q0_cnt++;
                    if (first_q0 < 0) first_q0 = cyc - start;
                end
            end
        end
`ifdef FP_AGING_EN
        checks++; if (first_q0 < 0 || first_q0 > 8) begin errors++; $display("FAIL aging_boost got first q0 grant at %0d want 1..8", first_q0); end
`else
        checks++; if (q0_cnt != 0) begin errors++; $display("FAIL starve_q0 got %0d q0 grants want 0", q0_cnt); end
`endif
        checks++; if (grants < 9) begin errors++; $display("FAIL aging_grants got %0d want >= 9", grants); end
    endtask

    task automatic test_random;
        pri4 = '0; emp4 = '1; rdy4 = 1'b0; do_reset;
        for (int i = 0; i < 400; i++) begin
            pri4 = 16'($urandom) & 16'h3333;
            emp4 = 4'($urandom & $urandom);
            rdy4 = $urandom_range(0, 3) != 0;
            reset = $urandom_range(0, 99) == 0;
            tick(1);
            checks++;
            if (gv4 !== m_valid || gid4 !== m_id || gpr4 !== m_prio) begin
                errors++;
                $display("FAIL random cyc %0d got v=%b id=%0d pr=%0d want v=%b id=%0d pr=%0d", cyc, gv4, gid4, gpr4, m_valid, m_id, m_prio);
            end
        end
        reset = 1'b0; emp4 = '1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_reset_abort;
        test_all_empty;
        test_tie_rotate;
        test_latency_prio0;
        test_hold_stable;
        test_wrap_n3;
        test_aging;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_rr_arbiter.md
FP_RR_ARBITER -- requirements
Module: fp_rr_arbiter

Interface
REQ-001 SHALL have parameter NUMBER_OF_QUEUES, default 4, number of request queues (legal range 2..64).
REQ-002 SHALL have parameter PRIORITY_SIZE, default 4, width of each queue priority (legal range >= 1).
REQ-003 SHALL have parameter AGE_SIZE, default 4, width of each per-queue age counter (used only with FP_AGING_EN).
REQ-004 SHALL have parameter AGE_THRESHOLD, default 12, age at which a queue is boosted (legal range 1..2^AGE_SIZE-1).
REQ-005 SHALL have port clock, input, 1 bit, rising-edge clock for all state.
REQ-006 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port priorities, input, NUMBER_OF_QUEUES x PRIORITY_SIZE bits, per-queue priority where larger value wins.
REQ-008 SHALL have port empty, input, NUMBER_OF_QUEUES bits, where 1 means the queue holds no packet.
REQ-009 SHALL have port grant_ready, input, 1 bit, consumer accepts the grant.
REQ-010 SHALL have port grant_valid, output, 1 bit, grant offered.
REQ-011 SHALL have port grant_id, output, $clog2(NUMBER_OF_QUEUES) bits, index of the granted queue.
REQ-012 SHALL have port grant_priority, output, PRIORITY_SIZE bits, user priority of the granted queue as sampled.

Function
REQ-013 SHALL register stage 1 each cycle: req[i] = ~empty[i]; key[i] = {req[i], priorities[i]}, so a non-empty queue with priority 0 beats an empty queue.
REQ-014 SHALL select in stage 2 the maximum key among all queues; equal keys are broken round-robin: first index at or after rr_ptr, scanning cyclically upward.
REQ-015 SHALL use FSM states IDLE, GRANT, FLUSH.
REQ-016 IDLE: when any stage-1 req is 1, SHALL load grant_id/grant_priority from the stage-2 winner, assert grant_valid, and go to GRANT; otherwise SHALL stay in IDLE with grant_valid=0.
REQ-017 GRANT: grant_valid, grant_id and grant_priority SHALL stay stable until grant_valid && grant_ready; a priority or empty change while waiting SHALL NOT alter the offer.
REQ-018 On handshake SHALL set rr_ptr <= (grant_id+1) mod NUMBER_OF_QUEUES, deassert grant_valid next cycle, and enter FLUSH.
REQ-019 FLUSH SHALL last exactly 2 cycles (2-bit counter) with grant_valid=0, so that the consumer's pop propagates through empty and stage 1, then go to IDLE.
REQ-020 Latency: empty[i] falling at edge t with the FSM in IDLE SHALL give grant_valid=1 after edge t+2 (2-cycle latency).
REQ-021 Back-to-back grants with grant_ready held high SHALL occur every 4 cycles (1 GRANT + 2 FLUSH + 1 IDLE).
REQ-022 rr_ptr SHALL wrap from NUMBER_OF_QUEUES-1 to 0; non-power-of-2 NUMBER_OF_QUEUES SHALL never produce grant_id >= NUMBER_OF_QUEUES.
REQ-023 A queue going empty while granted SHALL NOT retract the grant; the consumer handles the stale grant.

Reset
REQ-024 While reset=1 at an edge, SHALL set state=IDLE, grant_valid=0, grant_id=0, grant_priority=0, rr_ptr=0, flush counter=0, stage-1 registers=0, and all age counters=0.
REQ-025 Reset asserted in GRANT or FLUSH SHALL abort the operation; the first grant_valid after reset release SHALL appear no earlier than 2 cycles later.

Configuration
REQ-026 With macro FP_AGING_EN defined, SHALL keep a saturating AGE_SIZE counter per queue.
REQ-027 With FP_AGING_EN, each counter SHALL increment every cycle its queue is non-empty and not handshaked, and clear on that queue's handshake or while it is empty.
REQ-028 With FP_AGING_EN, a queue whose age >= AGE_THRESHOLD SHALL have key {1, aged=1, priority}, ranking above every non-aged queue; ties SHALL still be broken by round-robin.
REQ-029 Without FP_AGING_EN, SHALL instantiate no age logic; arbitration SHALL be pure fixed priority with round-robin tie-break, and AGE_SIZE and AGE_THRESHOLD SHALL be ignored.

Verification
REQ-030 Bench SHALL cover: N=4, empty=4'b1111 -> grant_valid stays 0 for 20 cycles.
REQ-031 Bench SHALL cover: priorities={3,9,5,9} (q3..q0), all non-empty, grant_ready=1 -> grant_id sequence 0,2,0,2 (ties rotate), each with grant_priority=9.
REQ-032 Bench SHALL cover: q1 only non-empty with priority 0 -> grant_id=1, grant_priority=0, grant_valid rises 2 cycles after empty[1] falls.
REQ-033 Bench SHALL cover: grant_ready=0 for 10 cycles while priorities change -> grant_id/grant_priority unchanged, then handshake, then 2 FLUSH cycles with grant_valid=0.
REQ-034 Bench SHALL cover: N=3, all equal priority -> grant_id 0,1,2,0 (wrap), never 3.
REQ-035 Bench SHALL cover, with FP_AGING_EN and AGE_THRESHOLD=4: q0 priority 1 vs q1 priority 15 always non-empty -> q0 is granted within 4 + 4 cycles of assertion; without the macro, q0 is never granted.
